// File: rtl/timer_counter.sv
// 64-bit timer with power-of-two prescaler, clear/word-write and debug halt.
// Optional halt FSM included when macro TIMER_HALT_EN is defined.
module timer_counter (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        halt_req,
    input  logic        dbg_mode,
    input  logic        counter_clear,
    input  logic [1:0]  counter_write_sel,
    input  logic [31:0] counter_write_data,
    output logic [63:0] cnt_val,
    output logic        cnt_tick,
    output logic        halt_ack_status
);

    logic [63:0] cnt_q, cnt_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [3:0]  div_q;
    logic [3:0]  div_exp;
    logic [7:0]  term;
    logic        run;
    logic        wr;
    logic        restart;

    assign div_exp = (div_val > 4'd8) ? 4'd8 : div_val;
    assign term    = div_en ? 8'((9'd1 << div_exp) - 9'd1) : 8'd0;
    assign wr      = counter_clear | (|counter_write_sel);
    assign restart = ~timer_en | ~div_en | wr | (div_val != div_q);

    // Reset gate keeps the pulse low while held in reset.
    assign cnt_tick = sys_rst_n & timer_en & run & (pcnt_q == term) & ~wr;

    always_comb begin
        cnt_d = cnt_q;
        if (counter_clear) begin
            cnt_d = 64'd0;
        end else if (|counter_write_sel) begin
            if (counter_write_sel[0]) cnt_d[31:0]  = counter_write_data;
            if (counter_write_sel[1]) cnt_d[63:32] = counter_write_data;
        end else if (cnt_tick) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (restart)
            pcnt_d = 8'd0;
        else if (run)
            pcnt_d = (pcnt_q == term) ? 8'd0 : pcnt_q + 8'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= 64'd0;
            pcnt_q <= 8'd0;
            div_q  <= 4'd0;
        end else begin
            cnt_q  <= cnt_d;
            pcnt_q <= pcnt_d;
            div_q  <= div_val;
        end
    end

    assign cnt_val = cnt_q;

`ifdef TIMER_HALT_EN
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;
    state_e state_q;
    logic   ack_q;

    // Ack is registered with the state so it rises one cycle after the request.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RUN;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: if (halt_req && dbg_mode) begin
                    state_q <= HALTED;
                    ack_q   <= 1'b1;
                end
                HALTED: if (!(halt_req && dbg_mode)) begin
                    state_q <= RUN;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign run             = (state_q == RUN);
    assign halt_ack_status = ack_q;
`else
    logic unused_halt;

    assign unused_halt     = halt_req ^ dbg_mode;
    assign run             = 1'b1;
    assign halt_ack_status = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed scenarios then random traffic
// against a cycle-level arithmetic reference model.
module tb_timer_counter;

`ifdef TIMER_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        timer_en = 1'b0;
    logic        div_en = 1'b0;
    logic [3:0]  div_val = 4'd0;
    logic        halt_req = 1'b0;
    logic        dbg_mode = 1'b0;
    logic        counter_clear = 1'b0;
    logic [1:0]  counter_write_sel = 2'd0;
    logic [31:0] counter_write_data = 32'd0;
    logic [63:0] cnt_val;
    logic        cnt_tick;
    logic        halt_ack_status;

    timer_counter dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .timer_en(timer_en),
        .div_en(div_en),
        .div_val(div_val),
        .halt_req(halt_req),
        .dbg_mode(dbg_mode),
        .counter_clear(counter_clear),
        .counter_write_sel(counter_write_sel),
        .counter_write_data(counter_write_data),
        .cnt_val(cnt_val),
        .cnt_tick(cnt_tick),
        .halt_ack_status(halt_ack_status)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        longint unsigned cnt;
        bit              tick;
        bit              ack;
        string           tag;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state
    longint unsigned m_cnt = 0;
    int              m_pcnt = 0;
    bit              m_halt = 0;
    int              m_prev_div = 0;

    task automatic step(input bit rst, input bit te, input bit de,
                        input int dv, input bit hr, input bit dm,
                        input bit clr, input int sel, input int unsigned wd,
                        input string tag);
        exp_t e;
        int   term;
        bit   wr;
        bit   tick;
        @(posedge sys_clk);
        #1;
        sys_rst_n          = rst;
        timer_en           = te;
        div_en             = de;
        div_val            = 4'(dv);
        halt_req           = hr;
        dbg_mode           = dm;
        counter_clear      = clr;
        counter_write_sel  = 2'(sel);
        counter_write_data = wd;
        if (!rst) begin
            m_cnt = 0;
            m_pcnt = 0;
            m_halt = 0;
            m_prev_div = 0;
            e.cnt = 0;
            e.tick = 0;
            e.ack = 0;
        end else begin
            term = de ? (1 << (dv > 8 ? 8 : dv)) - 1 : 0;
            wr   = clr || (sel != 0);
            tick = te && !m_halt && (m_pcnt == term) && !wr;
            e.cnt = m_cnt;
            e.tick = tick;
            e.ack = m_halt;
            if (clr) m_cnt = 0;
            else if (sel != 0) begin
                if (sel & 1) m_cnt = {m_cnt[63:32], wd};
                if (sel & 2) m_cnt = {wd, m_cnt[31:0]};
            end else if (tick) m_cnt = m_cnt + 1;
            if (!te || !de || wr || dv != m_prev_div) m_pcnt = 0;
            else if (!m_halt) m_pcnt = (m_pcnt == term) ? 0 : m_pcnt + 1;
            m_halt = HALT && hr && dm;
            m_prev_div = dv;
        end
        e.tag = tag;
        q.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (cnt_val !== e.cnt || cnt_tick !== e.tick ||
                halt_ack_status !== e.ack) begin
                miscompares++;
                $display("FAIL %s: got cnt=%h tick=%b ack=%b, want cnt=%h tick=%b ack=%b",
                         e.tag, cnt_val, cnt_tick, halt_ack_status,
                         e.cnt, e.tick, e.ack);
            end
        end
    end

    initial begin
        int dv;
        bit hr;
        bit dm;
        bit de;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "nodiv");
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, "clear");
        for (int i = 0; i < 33; i++) step(1, 1, 1, 3, 0, 0, 0, 0, 0, "div3");
        for (int i = 0; i < 3; i++) step(1, 1, 1, 3, 0, 0, 0, 0, 0, "div3b");
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0, 0, 0, 0, 0, "div1");
        step(1, 1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, "wr_lo");
        step(1, 1, 0, 0, 0, 0, 0, 2, 32'hFFFF_FFFF, "wr_hi");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "wrap64");
        step(1, 1, 0, 0, 0, 0, 0, 3, 0, "wr_zero");
        step(1, 1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, "wr_lo2");
        for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "carry32");
        step(1, 1, 0, 0, 0, 0, 1, 3, 32'h1234_5678, "clr_wr");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "post_clr");
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, "clear2");
        for (int i = 0; i < 3; i++) step(1, 1, 1, 2, 0, 0, 0, 0, 0, "pre_halt");
        for (int i = 0; i < 21; i++) step(1, 1, 1, 2, 1, 1, 0, 0, 0, "halted");
        for (int i = 0; i < 6; i++) step(1, 1, 1, 2, 0, 1, 0, 0, 0, "release");
        for (int i = 0; i < 10; i++) step(1, 1, 1, 2, 1, 0, 0, 0, 0, "nodbg");
        step(1, 1, 1, 2, 1, 1, 0, 0, 0, "halt2");
        step(0, 1, 1, 2, 1, 1, 0, 0, 0, "mid_rst");
        for (int i = 0; i < 8; i++) step(1, 1, 1, 2, 0, 0, 0, 0, 0, "after_rst");
        dv = 0;
        hr = 0;
        dm = 0;
        de = 1;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            int unsigned wd;
            if ($urandom_range(0, 40) == 0) dv = $urandom_range(0, 15);
            if ($urandom_range(0, 60) == 0) de = ~de;
            if ($urandom_range(0, 15) == 0) hr = ~hr;
            if ($urandom_range(0, 20) == 0) dm = ~dm;
            sel = ($urandom_range(0, 30) == 0) ? $urandom_range(1, 3) : 0;
            wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                              : $urandom;
            step($urandom_range(0, 400) != 0, $urandom_range(0, 9) != 0, de,
                 dv, hr, dm, $urandom_range(0, 80) == 0, sel, wd, "rand");
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
